// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for the shared add/sub arbiter: two requester
// handshakes plus the result handshake and the busy flag.
interface addsub_arbiter_if #(
  parameter int WIDTH = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_sub;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_sub;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_out;
  logic             resp_carr;
  logic             busy;

  modport master (
    output req0_valid, req0_sub, req0_a, req0_b,
    output req1_valid, req1_sub, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_out, resp_carr, busy
  );

  modport slave (
    input  req0_valid, req0_sub, req0_a, req0_b,
    input  req1_valid, req1_sub, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_out, resp_carr, busy
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one ripple add/sub datapath between two
// requesters; accept -> CALC -> registered response, one op per 3 cycles max.
module addsub_arbiter #(
  parameter int WIDTH = 3
) (
  input logic             clk,
  input logic             rst_n,
  addsub_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q, id_q;
  logic             resp_valid_q, resp_carr_q, resp_id_q;
  logic [WIDTH-1:0] resp_out_q;

  logic             grant0, grant1, ready0, ready1, busy;
  logic [WIDTH-1:0] b_x, sum;
  logic [WIDTH:0]   c_chain;

  // Grant depends only on state, last and the valids: no path from resp_ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 | grant1) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (resp_valid_q & bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready0 = grant0;
    ready1 = grant1;
    busy   = (state_q != IDLE);
  end

  // Shared ripple adder; subtraction via inverted b and carry-in of 1.
  always_comb begin
    b_x        = b_q ^ {WIDTH{sub_q}};
    sum        = '0;
    c_chain    = '0;
    c_chain[0] = sub_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]       = a_q[i] ^ b_x[i] ^ c_chain[i];
      c_chain[i+1] = (a_q[i] & b_x[i]) | (b_x[i] & c_chain[i]) | (c_chain[i] & a_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_out_q   <= '0;
      resp_carr_q  <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      if (grant0 | grant1) begin
        a_q    <= grant1 ? bus.req1_a   : bus.req0_a;
        b_q    <= grant1 ? bus.req1_b   : bus.req0_b;
        sub_q  <= grant1 ? bus.req1_sub : bus.req0_sub;
        id_q   <= grant1;
        last_q <= grant1;
      end
      if (state_q == CALC) begin
        resp_out_q   <= sum;
        resp_carr_q  <= c_chain[WIDTH];
        resp_id_q    <= id_q;
        resp_valid_q <= 1'b1;
      end else if (state_q == RESP && resp_valid_q && bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.busy       = busy;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_carr  = resp_carr_q;
  assign bus.resp_id    = resp_id_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed operations with literal expectations plus
// a per-cycle behavioural model of arbitration, latency and arithmetic.
module tb_addsub_arbiter;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_arbiter_if #(.WIDTH(W)) bus ();

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = computing, 2 = result offered.
  int         m_phase = 0;
  bit         m_known = 1'b0;
  bit         m_last  = 1'b1;
  bit [W-1:0] m_a, m_b, m_out;
  bit         m_sub, m_id, m_carr;

  always @(negedge clk) begin : model
    bit e0, e1;
    e0 = (m_phase == 0) && bus.req0_valid && (!bus.req1_valid || m_last);
    e1 = (m_phase == 0) && bus.req1_valid && (!bus.req0_valid || !m_last);
    if (m_known) begin
      chk("m_ready0", bus.req0_ready, e0);
      chk("m_ready1", bus.req1_ready, e1);
      chk("m_busy", bus.busy, m_phase != 0);
      chk("m_resp_valid", bus.resp_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("m_resp_out", bus.resp_out, m_out);
        chk("m_resp_carr", bus.resp_carr, m_carr);
        chk("m_resp_id", bus.resp_id, m_id);
      end
    end
    if (!rst_n) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_known = 1'b1;
    end else if (m_known) begin
      case (m_phase)
        0: if (e0 || e1) begin
             m_id    = e1;
             m_a     = e1 ? bus.req1_a : bus.req0_a;
             m_b     = e1 ? bus.req1_b : bus.req0_b;
             m_sub   = e1 ? bus.req1_sub : bus.req0_sub;
             m_last  = e1;
             m_phase = 1;
           end
        1: begin
             if (m_sub) begin
               m_carr = (m_a >= m_b);
               m_out  = m_a - m_b;
             end else begin
               {m_carr, m_out} = {1'b0, m_a} + {1'b0, m_b};
             end
             m_phase = 2;
           end
        default: if (bus.resp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic drive(input int r, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_sub = s; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_sub = s; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic release_req(input int r);
    if (r == 0) begin
      bus.req0_valid = 1'b0; bus.req0_a = ~bus.req0_a; bus.req0_b = ~bus.req0_b;
    end else begin
      bus.req1_valid = 1'b0; bus.req1_a = ~bus.req1_a; bus.req1_b = ~bus.req1_b;
    end
  endtask

  task automatic wait_ready(input int r, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (r == 0) ? bus.req0_ready : bus.req1_ready;
    end
    chk({tag, "_accept"}, ok, 1);
  endtask

  task automatic run_op(input int r, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eo, input bit ec, input string tag);
    bit ok;
    @(posedge clk); #1;
    drive(r, s, a, b);
    wait_ready(r, tag, ok);
    @(posedge clk); #1;
    release_req(r);
    if (!ok) return;
    @(negedge clk);
    chk({tag, "_calc_valid"}, bus.resp_valid, 0);
    chk({tag, "_calc_busy"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_valid"}, bus.resp_valid, 1);
    chk({tag, "_out"}, bus.resp_out, eo);
    chk({tag, "_carr"}, bus.resp_carr, ec);
    chk({tag, "_id"}, bus.resp_id, r);
    @(negedge clk);
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    int got;
    logic [31:0] ids [4];
    logic [31:0] outs [4];
    logic [31:0] exp_ids [4];
    logic [31:0] exp_outs [4];

    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_sub = 0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_sub = 0; bus.req1_a = '0; bus.req1_b = '0;
    bus.resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_out", bus.resp_out, 0);
    chk("rst_carr", bus.resp_carr, 0);
    chk("rst_id", bus.resp_id, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(0, 0, 3'd3, 3'd2, 3'd5, 1'b0, "add_3_2");
    run_op(1, 0, 3'd7, 3'd1, 3'd0, 1'b1, "add_7_1");
    run_op(1, 1, 3'd5, 3'd2, 3'd3, 1'b1, "sub_5_2");
    run_op(0, 1, 3'd2, 3'd5, 3'd5, 1'b0, "sub_2_5");
    run_op(0, 1, 3'd4, 3'd4, 3'd0, 1'b1, "sub_4_4");

    // Backpressure: hold the result 4 cycles with a competing request pending.
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    drive(1, 0, 3'd4, 3'd2);
    wait_ready(1, "hold", ok);
    @(posedge clk); #1 release_req(1);
    @(negedge clk); @(negedge clk);
    chk("hold_first_valid", bus.resp_valid, 1);
    @(posedge clk); #1 drive(0, 0, 3'd1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_out", bus.resp_out, 6);
      chk("hold_id", bus.resp_id, 1);
      chk("hold_ready0", bus.req0_ready, 0);
      chk("hold_ready1", bus.req1_ready, 0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    release_req(0);
    @(negedge clk);
    chk("hold_pre_hs_valid", bus.resp_valid, 1);
    @(negedge clk);
    chk("hold_post_hs_busy", bus.busy, 0);
    chk("hold_post_hs_valid", bus.resp_valid, 0);

    // Reset while computing 3+3 discards the operation.
    @(posedge clk); #1 drive(0, 0, 3'd3, 3'd3);
    wait_ready(0, "rst_calc", ok);
    @(posedge clk); #1;
    release_req(0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_calc_valid", bus.resp_valid, 0);
    chk("rst_calc_busy", bus.busy, 0);
    chk("rst_calc_out", bus.resp_out, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_calc_no_resp", bus.resp_valid, 0);
    end

    // Both requesters persistently valid: grants alternate starting with 0.
    exp_ids  = '{0, 1, 0, 1};
    exp_outs = '{2, 5, 2, 5};
    @(posedge clk); #1;
    drive(0, 0, 3'd1, 3'd1);
    drive(1, 1, 3'd6, 3'd1);
    got = 0;
    for (int i = 0; i < 60 && got < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) begin
        ids[got]  = bus.resp_id;
        outs[got] = bus.resp_out;
        got++;
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("alt_count", got, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got) begin
        chk("alt_id", ids[i], exp_ids[i]);
        chk("alt_out", outs[i], exp_outs[i]);
      end
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit ripple adder/subtractor between two requesters. Each requester issues an add or subtract through a valid/ready handshake. The block latches the winning operands, drives the shared datapath for one cycle and returns the registered result, carry and requester ID on a response handshake. It sits between the requesting control logic and the single adder-cum-subtractor datapath, so two clients can use that datapath without contention.

## Interface
- WIDTH, 3, operand and result width in bits (minimum 2)
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_sub  input  1  requester 0 op: 0 = add, 1 = subtract (a − b)
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_sub, req1_a, req1_b  same widths and meanings for requester 1
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes the result
- resp_id  output  1  requester that owns the result (0 or 1)
- resp_out  output  WIDTH  sum or difference, modulo 2^WIDTH
- resp_carr  output  1  carry-out of the MSB full adder
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, CALC, RESP; one-hot or binary encoding is acceptable. Reset state is IDLE.
- IDLE:
  - Grant at most one requester per cycle.
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not granted last. The `last` pointer resets to 1, so requester 0 wins first after reset.
  - reqN_ready is asserted combinationally only for the granted requester, and only in IDLE.
  - A transfer happens when reqN_valid & reqN_ready. On transfer: latch a, b, sub and the ID; update `last` to the ID; go to CALC.
- CALC:
  - Drive the shared datapath with the latched operands:
    - carry-in = sub
    - b input = b XOR {WIDTH{sub}}
    - ripple through WIDTH full adders (sum = a^b^c; carry = ab | bc | ca)
  - Register out into resp_out, the final carry into resp_carr, and the latched ID into resp_id.
  - Set resp_valid; go to RESP.
- RESP:
  - Hold resp_* stable while resp_ready = 0.
  - On resp_valid & resp_ready: clear resp_valid and go to IDLE.
  - No new request is accepted in RESP or CALC; both ready outputs are 0.
- Arithmetic: resp_out = (a + (b ^ mask) + sub) mod 2^WIDTH.
  - Add: resp_carr = unsigned overflow.
  - Subtract: resp_carr = 1 means a ≥ b (no borrow); resp_carr = 0 means a < b, and resp_out is the two's-complement difference.
- Requester inputs are sampled only at the accept edge. Later changes do not affect the in-flight result.
- A requester may drop valid before it is granted; no transfer occurs and arbitration re-evaluates the next cycle.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = IDLE, last = 1
  - resp_valid = 0, resp_out = 0, resp_carr = 0, resp_id = 0, busy = 0
  - req0_ready and req1_ready evaluate to 0 on the cycle after reset
  - Any in-flight operation is discarded and no response is produced.
- Accept at edge E0. CALC runs during cycle E0→E1. resp_valid = 1 after E1 (2-edge latency).
- If resp_ready = 1 at E2, resp_valid = 0 after E2 and the block is back in IDLE. The earliest next accept is at E3.
- Peak throughput: 1 operation per 3 cycles.
- reqN_ready depends only on state, `last` and the valid inputs. There is no combinational path from resp_ready to reqN_ready.
- Simultaneous valid on both requesters in consecutive operations: grants strictly alternate 0, 1, 0, 1.
- A single persistently valid requester is granted every operation; `last` does not block it.
- Reset asserted in CALC or RESP takes priority over all transitions.

## Test plan
- After reset, req0 add a=3, b=2 → req0_ready one cycle; 2 edges later resp_valid=1, resp_id=0, resp_out=5, resp_carr=0.
- req1 add a=7, b=1 → resp_out=0, resp_carr=1. Then req1 sub a=5, b=2 → resp_out=3, resp_carr=1.
- req0 sub a=2, b=5 → resp_out=5 (3'b101 = −3), resp_carr=0. Then sub a=4, b=4 → resp_out=0, resp_carr=1.
- Both valid continuously for four operations (req0: 1+1, req1: 6−1) → resp_id sequence 0,1,0,1; outputs 2,5,2,5; ready never high for both in the same cycle.
- resp_ready held low 4 cycles in RESP with result 6 → resp_valid, resp_out=6 and resp_id stable; both ready outputs 0; IDLE only after the handshake.
- rst_n pulsed low during CALC of 3+3 → next cycle resp_valid=0, busy=0, resp_out=0; no response appears; the next request behaves as after power-on (req0 wins a tie).
